// File: rtl/id_ex_stage.sv
// ID/EX pipeline register stage with hazard support.
// Captures decode-stage operands and control into E registers, then selects
// ALU operands from those registers. When EX_FORWARD_EN is defined, results
// still in flight in MEM or WB can replace the stale register-file values.
// The stage also raises the load-use stall request for decode and keeps a
// saturating count of the bubbles it has inserted.
//
// Configuration macro:
//   EX_FORWARD_EN - when defined, MEM/WB results are forwarded to the
//                   operands. When undefined, operands come straight from
//                   the E registers and the forward inputs are ignored.
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       writereg_d,
  input  logic [2:0]       alucontrol_d,
  input  logic             alusrc_d,
  input  logic [2:0]       ctrl_d,
  input  logic [WIDTH-1:0] aluout_m,
  input  logic [WIDTH-1:0] result_w,
  input  logic [4:0]       writereg_m,
  input  logic [4:0]       writereg_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  output logic [WIDTH-1:0] srca_e,
  output logic [WIDTH-1:0] srcb_e,
  output logic [2:0]       alucontrol_e,
  output logic [WIDTH-1:0] writedata_e,
  output logic [4:0]       writereg_e,
  output logic [2:0]       ctrl_e,
  output logic             lwstall_d,
  output logic [7:0]       bubble_cnt
);

  // ctrl bundle layout: {regwrite, memtoreg, memwrite}
  localparam int CTRL_MEMTOREG = 1;
  localparam logic [7:0] BUBBLE_MAX = 8'hFF;

  // E-stage registers and their next-state values
  logic [WIDTH-1:0] rd1_e_q,        rd1_e_d;
  logic [WIDTH-1:0] rd2_e_q,        rd2_e_d;
  logic [WIDTH-1:0] signimm_e_q,    signimm_e_d;
  logic [4:0]       rs_e_q,         rs_e_d;
  logic [4:0]       rt_e_q,         rt_e_d;
  logic [4:0]       writereg_e_q,   writereg_e_d;
  logic [2:0]       alucontrol_e_q, alucontrol_e_d;
  logic             alusrc_e_q,     alusrc_e_d;
  logic [2:0]       ctrl_e_q,       ctrl_e_d;
  logic [7:0]       bubble_cnt_q,   bubble_cnt_d;

  // Combinational operand values
  logic [WIDTH-1:0] srca_s;
  logic [WIDTH-1:0] writedata_s;
  logic [WIDTH-1:0] srcb_s;
  logic             lwstall_s;

`ifdef EX_FORWARD_EN
  // Select the freshest copy of a source register: MEM beats WB beats the
  // value read in decode. Register 0 is hardwired and never forwarded.
  function automatic logic [WIDTH-1:0] fwd_pick(
    input logic [4:0]       src_reg,
    input logic [WIDTH-1:0] reg_val,
    input logic             rw_m,
    input logic [4:0]       wr_m,
    input logic [WIDTH-1:0] val_m,
    input logic             rw_w,
    input logic [4:0]       wr_w,
    input logic [WIDTH-1:0] val_w
  );
    logic [WIDTH-1:0] pick;
    if (rw_m && (wr_m != 5'd0) && (wr_m == src_reg)) begin
      pick = val_m;
    end else if (rw_w && (wr_w != 5'd0) && (wr_w == src_reg)) begin
      pick = val_w;
    end else begin
      pick = reg_val;
    end
    return pick;
  endfunction
`endif

  // Next-state selection for the E registers: flush beats stall beats load
  always_comb begin
    rd1_e_d        = rd1_e_q;
    rd2_e_d        = rd2_e_q;
    signimm_e_d    = signimm_e_q;
    rs_e_d         = rs_e_q;
    rt_e_d         = rt_e_q;
    writereg_e_d   = writereg_e_q;
    alucontrol_e_d = alucontrol_e_q;
    alusrc_e_d     = alusrc_e_q;
    ctrl_e_d       = ctrl_e_q;
    if (flush_e) begin
      // Bubble: kill all side effects, leave the data fields as they were
      ctrl_e_d       = 3'b000;
      alucontrol_e_d = 3'b000;
    end else if (stall_e) begin
      // Hold the current instruction
      ctrl_e_d       = ctrl_e_q;
      alucontrol_e_d = alucontrol_e_q;
    end else begin
      rd1_e_d        = rd1_d;
      rd2_e_d        = rd2_d;
      signimm_e_d    = signimm_d;
      rs_e_d         = rs_d;
      rt_e_d         = rt_d;
      writereg_e_d   = writereg_d;
      alucontrol_e_d = alucontrol_d;
      alusrc_e_d     = alusrc_d;
      ctrl_e_d       = ctrl_d;
    end
  end

  // Bubble counter: one step per flushed edge, sticks at the top value
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (flush_e && (bubble_cnt_q != BUBBLE_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + 8'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // State update; reset wipes every register so nothing of a held
  // instruction survives
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_e_q        <= '0;
      rd2_e_q        <= '0;
      signimm_e_q    <= '0;
      rs_e_q         <= 5'd0;
      rt_e_q         <= 5'd0;
      writereg_e_q   <= 5'd0;
      alucontrol_e_q <= 3'b000;
      alusrc_e_q     <= 1'b0;
      ctrl_e_q       <= 3'b000;
      bubble_cnt_q   <= 8'd0;
    end else begin
      rd1_e_q        <= rd1_e_d;
      rd2_e_q        <= rd2_e_d;
      signimm_e_q    <= signimm_e_d;
      rs_e_q         <= rs_e_d;
      rt_e_q         <= rt_e_d;
      writereg_e_q   <= writereg_e_d;
      alucontrol_e_q <= alucontrol_e_d;
      alusrc_e_q     <= alusrc_e_d;
      ctrl_e_q       <= ctrl_e_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

`ifdef EX_FORWARD_EN
  // Forwarded operands A and B (B doubles as the store data)
  always_comb begin
    srca_s      = fwd_pick(rs_e_q, rd1_e_q, regwrite_m, writereg_m, aluout_m,
                           regwrite_w, writereg_w, result_w);
    writedata_s = fwd_pick(rt_e_q, rd2_e_q, regwrite_m, writereg_m, aluout_m,
                           regwrite_w, writereg_w, result_w);
  end
`else
  // Without forwarding the operands are the values read in decode
  always_comb begin
    srca_s      = rd1_e_q;
    writedata_s = rd2_e_q;
  end

  // Forward inputs and rs_e only matter when forwarding is built in
  logic unused_fwd_s;
  assign unused_fwd_s = ^{aluout_m, result_w, writereg_m, writereg_w,
                          regwrite_m, regwrite_w, rs_e_q};
`endif

  // Operand B chooses between the immediate and the (forwarded) rt value
  always_comb begin
    srcb_s = writedata_s;
    if (alusrc_e_q) begin
      srcb_s = signimm_e_q;
    end else begin
      srcb_s = writedata_s;
    end
  end

  // Load-use hazard: a load in E whose target is read by decode
  always_comb begin
    lwstall_s = 1'b0;
    if (ctrl_e_q[CTRL_MEMTOREG]) begin
      lwstall_s = (rt_e_q == rs_d) || (rt_e_q == rt_d);
    end else begin
      lwstall_s = 1'b0;
    end
  end

  assign srca_e       = srca_s;
  assign srcb_e       = srcb_s;
  assign writedata_e  = writedata_s;
  assign alucontrol_e = alucontrol_e_q;
  assign writereg_e   = writereg_e_q;
  assign ctrl_e       = ctrl_e_q;
  assign lwstall_d    = lwstall_s;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-edge behaviour
// plus hand sequences for forwarding, bubble saturation and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_e = 1'b0, flush_e = 1'b0;
  logic [31:0] rd1_d = '0, rd2_d = '0, signimm_d = '0;
  logic [4:0]  rs_d = '0, rt_d = '0, writereg_d = '0;
  logic [2:0]  alucontrol_d = '0;
  logic        alusrc_d = 1'b0;
  logic [2:0]  ctrl_d = '0;
  logic [31:0] aluout_m = '0, result_w = '0;
  logic [4:0]  writereg_m = '0, writereg_w = '0;
  logic        regwrite_m = 1'b0, regwrite_w = 1'b0;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucontrol_e, ctrl_e;
  logic [4:0]  writereg_e;
  logic        lwstall_d;
  logic [7:0]  bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
    .rs_d(rs_d), .rt_d(rt_d), .writereg_d(writereg_d),
    .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d), .ctrl_d(ctrl_d),
    .aluout_m(aluout_m), .result_w(result_w),
    .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e), .ctrl_e(ctrl_e),
    .lwstall_d(lwstall_d), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [2:0]  aluc;
    logic        alusrc;
    logic [2:0]  ctrl;
    logic [31:0] e_srca;
    logic [31:0] e_srcb;
    logic [31:0] e_wd;
    logic [2:0]  e_aluc;
    logic [4:0]  e_wr;
    logic [2:0]  e_ctrl;
    logic        e_lw;
    logic [7:0]  e_bcnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".srca"}, srca_e, 32'd0);
    chk({tag, ".srcb"}, srcb_e, 32'd0);
    chk({tag, ".wd"}, writedata_e, 32'd0);
    chk({tag, ".aluc"}, {29'd0, alucontrol_e}, 32'd0);
    chk({tag, ".wr"}, {27'd0, writereg_e}, 32'd0);
    chk({tag, ".ctrl"}, {29'd0, ctrl_e}, 32'd0);
    chk({tag, ".lw"}, {31'd0, lwstall_d}, 32'd0);
    chk({tag, ".bcnt"}, {24'd0, bubble_cnt}, 32'd0);
  endtask

  initial begin
    // stall flush rd1 rd2 imm rs rt wr aluc alusrc ctrl | srca srcb wd aluc wr ctrl lw bcnt
    vecs[0] = '{1'b0, 1'b0, 32'd5, 32'h11, 32'd7, 5'd1, 5'd2, 5'd3, 3'd2, 1'b1, 3'b100,
                32'd5, 32'd7, 32'h11, 3'd2, 5'd3, 3'b100, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 32'hA5A5A5A5, 32'h12345678, 32'hFFFFFFF0, 5'd4, 5'd9, 5'd10, 3'd6, 1'b0, 3'b010,
                32'hA5A5A5A5, 32'h12345678, 32'h12345678, 3'd6, 5'd10, 3'b010, 1'b1, 8'd0};
    vecs[2] = '{1'b1, 1'b0, 32'h1, 32'h2, 32'h3, 5'd4, 5'd4, 5'd1, 3'd1, 1'b1, 3'b111,
                32'hA5A5A5A5, 32'h12345678, 32'h12345678, 3'd6, 5'd10, 3'b010, 1'b0, 8'd0};
    vecs[3] = '{1'b1, 1'b0, 32'h4, 32'h5, 32'h6, 5'd9, 5'd4, 5'd2, 3'd2, 1'b1, 3'b101,
                32'hA5A5A5A5, 32'h12345678, 32'h12345678, 3'd6, 5'd10, 3'b010, 1'b1, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 32'h7, 32'h8, 32'h9, 5'd7, 5'd7, 5'd3, 3'd3, 1'b0, 3'b001,
                32'hA5A5A5A5, 32'h12345678, 32'h12345678, 3'd6, 5'd10, 3'b010, 1'b0, 8'd0};
    vecs[5] = '{1'b0, 1'b1, 32'h77, 32'h88, 32'h99, 5'd9, 5'd9, 5'd12, 3'd5, 1'b1, 3'b110,
                32'hA5A5A5A5, 32'h12345678, 32'h12345678, 3'd0, 5'd10, 3'b000, 1'b0, 8'd1};
    vecs[6] = '{1'b0, 1'b0, 32'h100, 32'h200, 32'h300, 5'd5, 5'd6, 5'd7, 3'd3, 1'b0, 3'b111,
                32'h100, 32'h200, 32'h200, 3'd3, 5'd7, 3'b111, 1'b1, 8'd1};
    vecs[7] = '{1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 32'hCAFE, 5'd1, 5'd2, 5'd20, 3'd4, 1'b1, 3'b011,
                32'h100, 32'h200, 32'h200, 3'd0, 5'd7, 3'b000, 1'b0, 8'd2};
    vecs[8] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h80000000, 5'd31, 5'd31, 5'd31, 3'd7, 1'b1, 3'b001,
                32'hFFFFFFFF, 32'h80000000, 32'h0, 3'd7, 5'd31, 3'b001, 1'b0, 8'd2};

    // Reset state, with inputs that would otherwise load something
    rd1_d = 32'h1234; ctrl_d = 3'b111; rs_d = 5'd3; rt_d = 5'd3;
    reset = 1'b1;
    tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Table: drive one vector per edge, check outputs just after the edge
    for (int i = 0; i < 9; i++) begin
      stall_e = vecs[i].stall; flush_e = vecs[i].flush;
      rd1_d = vecs[i].rd1; rd2_d = vecs[i].rd2; signimm_d = vecs[i].imm;
      rs_d = vecs[i].rs; rt_d = vecs[i].rt; writereg_d = vecs[i].wr;
      alucontrol_d = vecs[i].aluc; alusrc_d = vecs[i].alusrc; ctrl_d = vecs[i].ctrl;
      tick();
      chk($sformatf("v%0d.srca", i), srca_e, vecs[i].e_srca);
      chk($sformatf("v%0d.srcb", i), srcb_e, vecs[i].e_srcb);
      chk($sformatf("v%0d.wd", i), writedata_e, vecs[i].e_wd);
      chk($sformatf("v%0d.aluc", i), {29'd0, alucontrol_e}, {29'd0, vecs[i].e_aluc});
      chk($sformatf("v%0d.wr", i), {27'd0, writereg_e}, {27'd0, vecs[i].e_wr});
      chk($sformatf("v%0d.ctrl", i), {29'd0, ctrl_e}, {29'd0, vecs[i].e_ctrl});
      chk($sformatf("v%0d.lw", i), {31'd0, lwstall_d}, {31'd0, vecs[i].e_lw});
      chk($sformatf("v%0d.bcnt", i), {24'd0, bubble_cnt}, {24'd0, vecs[i].e_bcnt});
    end

    // Forwarding: load rs=8 rt=3, then hold and vary the MEM/WB inputs
    stall_e = 1'b0; flush_e = 1'b0;
    rd1_d = 32'h55; rd2_d = 32'h66; signimm_d = 32'h77;
    rs_d = 5'd8; rt_d = 5'd3; writereg_d = 5'd4; alucontrol_d = 3'd2;
    alusrc_d = 1'b0; ctrl_d = 3'b100;
    tick();
    stall_e = 1'b1;
    regwrite_m = 1'b1; writereg_m = 5'd8; aluout_m = 32'h10;
    regwrite_w = 1'b1; writereg_w = 5'd8; result_w = 32'h20;
    #1;
`ifdef EX_FORWARD_EN
    chk("fwd.mem_wins", srca_e, 32'h10);
`else
    chk("fwd.mem_wins", srca_e, 32'h55);
`endif
    chk("fwd.b_nomatch", writedata_e, 32'h66);
    writereg_m = 5'd0;
    #1;
`ifdef EX_FORWARD_EN
    chk("fwd.wb_a", srca_e, 32'h20);
`else
    chk("fwd.wb_a", srca_e, 32'h55);
`endif
    writereg_w = 5'd0;
    #1;
    chk("fwd.none_a", srca_e, 32'h55);
    writereg_m = 5'd3;
    #1;
`ifdef EX_FORWARD_EN
    chk("fwd.mem_b", writedata_e, 32'h10);
    chk("fwd.mem_srcb", srcb_e, 32'h10);
`else
    chk("fwd.mem_b", writedata_e, 32'h66);
    chk("fwd.mem_srcb", srcb_e, 32'h66);
`endif
    regwrite_m = 1'b0;
    #1;
    chk("fwd.rw_off_b", writedata_e, 32'h66);
    regwrite_w = 1'b0; writereg_m = 5'd0; aluout_m = '0; result_w = '0;

    // Reset in the middle of a stall discards the held instruction
    reset = 1'b1; rs_d = 5'd0; rt_d = 5'd0;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0; stall_e = 1'b0;

    // Saturating bubble count over 260 flushes
    flush_e = 1'b1;
    for (int c = 0; c < 255; c++) tick();
    chk("bcnt.255", {24'd0, bubble_cnt}, 32'd255);
    for (int c = 0; c < 5; c++) tick();
    chk("bcnt.sat", {24'd0, bubble_cnt}, 32'd255);
    flush_e = 1'b0;
    reset = 1'b1;
    tick();
    chk_all_zero("final_reset");
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall_e  in  1  hold all E registers.
REQ-005 SHALL have port flush_e  in  1  load a bubble into E registers.
REQ-006 SHALL have port rd1_d  in  WIDTH  decode register-file read data A.
REQ-007 SHALL have port rd2_d  in  WIDTH  decode register-file read data B.
REQ-008 SHALL have port signimm_d  in  WIDTH  decode sign-extended immediate.
REQ-009 SHALL have port rs_d  in  5  decode source register A.
REQ-010 SHALL have port rt_d  in  5  decode source register B.
REQ-011 SHALL have port writereg_d  in  5  decode destination register.
REQ-012 SHALL have port alucontrol_d  in  3  decode ALU operation code.
REQ-013 SHALL have port alusrc_d  in  1  1 = srcb from immediate.
REQ-014 SHALL have port ctrl_d  in  3  {regwrite, memtoreg, memwrite}.
REQ-015 SHALL have port aluout_m  in  WIDTH  MEM-stage ALU result.
REQ-016 SHALL have port result_w  in  WIDTH  WB-stage result.
REQ-017 SHALL have port writereg_m  in  5  MEM-stage destination.
REQ-018 SHALL have port writereg_w  in  5  WB-stage destination.
REQ-019 SHALL have port regwrite_m  in  1  MEM-stage write enable.
REQ-020 SHALL have port regwrite_w  in  1  WB-stage write enable.
REQ-021 SHALL have port srca_e  out  WIDTH  ALU operand A.
REQ-022 SHALL have port srcb_e  out  WIDTH  ALU operand B.
REQ-023 SHALL have port alucontrol_e  out  3  ALU operation code.
REQ-024 SHALL have port writedata_e  out  WIDTH  store data (forwarded rt value).
REQ-025 SHALL have port writereg_e  out  5  E-stage destination.
REQ-026 SHALL have port ctrl_e  out  3  registered {regwrite, memtoreg, memwrite}.
REQ-027 SHALL have port lwstall_d  out  1  load-use hazard, stall decode.
REQ-028 SHALL have port bubble_cnt  out  8  saturating count of bubbles inserted.

Function
REQ-029 Each edge, priority reset > flush_e > stall_e > load: flush clears ctrl_e and alucontrol_e to 0 (data regs don't-care, held); stall holds all E registers; otherwise all *_d inputs plus rs_d, rt_d captured into E registers.
REQ-030 Latency SHALL be one cycle: values captured at edge N appear on E outputs after edge N.
REQ-031 Forward A: if regwrite_m, writereg_m!=0, writereg_m==rs_e -> aluout_m; else if regwrite_w, writereg_w!=0, writereg_w==rs_e -> result_w; else registered rd1; result drives srca_e.
REQ-032 Forward B SHALL use the same priority on rt_e and registered rd2, driving writedata_e.
REQ-033 srcb_e SHALL equal registered signimm when registered alusrc=1, else writedata_e.
REQ-034 Forwarding and operand muxes SHALL be combinational from E registers and forward inputs, no added cycle.
REQ-035 lwstall_d SHALL be combinational: ctrl_e[1] (memtoreg) AND (rt_e==rs_d OR rt_e==rt_d); 0 when ctrl_e[1]=0.
REQ-036 bubble_cnt SHALL increment by 1 on each edge where flush_e=1 and reset=0, saturating at 255.
REQ-037 Simultaneous stall_e and flush_e SHALL produce a bubble and count it.

Reset
REQ-038 reset=1 at an edge SHALL clear every E register (all data, rs_e, rt_e, writereg_e, alucontrol_e, ctrl_e) and bubble_cnt to 0, overriding stall/flush; srca_e, srcb_e, writedata_e, lwstall_d SHALL read 0 afterwards absent forwarding matches.
REQ-039 Reset mid-operation SHALL discard the held instruction; no partial state survives.

Configuration
REQ-040 Macro EX_FORWARD_EN defined: forwarding per REQ-031/032; undefined: srca_e = registered rd1, writedata_e = registered rd2, forward inputs ignored; all else unchanged.

Verification
REQ-041 Load rd1_d=5, signimm_d=7, alusrc_d=1, ctrl_d=3'b100 -> next cycle srca_e=5, srcb_e=7, ctrl_e=3'b100.
REQ-042 rs_e=8, regwrite_m=1, writereg_m=8, aluout_m=0x10, regwrite_w=1, writereg_w=8, result_w=0x20 -> srca_e=0x10 (MEM wins); with writereg_m=0, writereg_w=0 -> registered rd1.
REQ-043 ctrl_e=3'b010, rt_e=9, rs_d=9 -> lwstall_d=1; rs_d=rt_d=4 -> lwstall_d=0.
REQ-044 stall_e=1 for 3 cycles with changing *_d -> E outputs constant; stall_e=flush_e=1 -> ctrl_e=0, bubble_cnt+1.
REQ-045 260 consecutive flush cycles -> bubble_cnt=255; then reset -> all outputs 0.
REQ-046 Build without EX_FORWARD_EN, REQ-042 stimulus -> srca_e = registered rd1.
